scc_tone_generator_mux: RTL and testbench
=========================================

// Module: scc_tone_generator_mux
// PURPOSE
// - Time-multiplexed N-channel wave-table tone generator: one shared step datapath serves all channels round-robin.
// - Per-channel down-counters and wave addresses live in internal register arrays.
// - Sits between the register file (frequency, reset requests) and the wave-memory read / mixer pipeline.
// - Emits one (channel, wave_address) pair per slot. Sticky reset requests guarantee no address-reset pulse is lost.
// PARAMETERS
// - CH_NUM      5   number of channels (>=2)
// - FREQ_WIDTH  12  frequency counter width
// - ADDR_WIDTH  5   wave-table address width (table depth 2**ADDR_WIDTH)
// - MIN_FREQ    9   reg_frequency_count below this value freezes the channel (address held, counter idle)
// - CH_W        $clog2(CH_NUM), localparam
// PORTS
// - nreset               in   1                    asynchronous reset, active low
// - clk                  in   1                    sole clock
// - enable               in   1                    slot strobe; one channel serviced per high cycle
// - reg_frequency_count  in   CH_NUM*FREQ_WIDTH    per-channel reload value; ch k at [k*FREQ_WIDTH +: FREQ_WIDTH]
// - address_reset        in   CH_NUM               per-channel reset request, single-cycle pulse
// - wave_valid           out  1                    wave_channel/wave_address valid this cycle
// - wave_channel         out  CH_W                 channel of the presented address
// - wave_address         out  ADDR_WIDTH           wave-memory address (pre-step value) of wave_channel
// - slot_sync            out  1                    high with wave_valid when wave_channel==0
// BEHAVIOUR
// - Reset (nreset=0, async): all counters 0, all addresses 0, pending resets 0, slot 0; outputs wave_valid=0, wave_channel=0, wave_address=0, slot_sync=0.
// - Slot counter:
//   - advances only on enable: 0,1,..,CH_NUM-1,0.
//   - enable=0: state frozen, wave_valid=0 next cycle.
// - Pending-reset flags:
//   - pend[k] is set by address_reset[k] on any cycle.
//   - pend[k] is cleared when slot k is serviced.
//   - A pulse on the same cycle slot k is serviced is applied immediately and not re-latched.
// - Step for serviced channel s (registered on enable), with cnt = counter[s], f = reg[s]:
//   - reset (pend[s] | address_reset[s]): cnt <= f; addr <= 0.
//   - else f < MIN_FREQ: hold cnt and addr.
//   - else cnt==0: cnt <= f; addr <= addr+1 (wraps modulo 2**ADDR_WIDTH).
//   - else: cnt <= cnt-1.
//   - Priority: reset > freeze > end > count.
// - Output latency: 1 clk after the enable cycle.
//   - wave_valid=1, wave_channel=s, wave_address = addr[s] before the step (same-slot reset still presents the old address).
// - Frequency change mid-count takes effect at the next reload only.
// - Effective period per channel: (f+1) services = (f+1)*CH_NUM enables per address step.
// - Arithmetic: unsigned; counter decrement never underflows (0 reloads).
// - nreset mid-operation: immediate clear; first valid output follows the first enable after release, channel 0.
// STRUCTURE
// - Shared package scc_pkg:
//   - default widths: SCC_FREQ_WIDTH=12, SCC_ADDR_WIDTH=5, SCC_CH_NUM=5.
//   - SCC_MIN_FREQ=9.
// - Sub-module scc_tone_step: purely combinational next-state of one channel.
//   - inputs: cnt, addr, f, reset, freeze.
//   - outputs: cnt_next, addr_next.
//   - Instantiated once, fed by muxed array entries.
// - Top holds: slot counter, pend vector, counter/address arrays (flip-flops; CH_NUM small), output registers.
// TESTING
// - Reset then idle:
//   - nreset low, enable=0 -> all outputs 0.
//   - After release, enable held low 10 cycles -> wave_valid stays 0.
// - Steady tone:
//   - CH_NUM=5, all f=9, enable every cycle.
//   - Ch0 address increments once per 10 services (50 clks).
//   - Address wraps 31->0.
//   - wave_channel sequence 0,1,2,3,4,0.
// - Freeze: f[2]=8 -> ch2 address constant over 500 clks; other channels unaffected.
// - Lost-pulse guard:
//   - address_reset[3] pulsed while slot 0 is active.
//   - At slot 3 service: counter reloaded, next ch3 presentation shows address 0.
//   - A second pulse before servicing yields exactly one reset.
// - Simultaneous events: ch1 counter==0 and address_reset[1] in its slot -> addr=0 (reset wins), counter=f[1].
// - Gated enable and mid-run reset:
//   - enable 1-of-3 cycles -> same address sequence, stretched 3x.
//   - nreset asserted mid-slot -> outputs 0 immediately.
//   - Restart at channel 0, address 0.

Source files
------------

// File: rtl/scc_pkg.sv
// -----------------------------------------------------------------------------
// scc_pkg
// Shared defaults for the time-multiplexed wave-table tone generator.
//   SCC_FREQ_WIDTH : width of the per-channel frequency down-counter
//   SCC_ADDR_WIDTH : wave-table address width (table depth 2**SCC_ADDR_WIDTH)
//   SCC_CH_NUM     : number of channels sharing the step datapath
//   SCC_MIN_FREQ   : reload values below this freeze a channel
// -----------------------------------------------------------------------------
package scc_pkg;

    localparam int SCC_FREQ_WIDTH = 12;
    localparam int SCC_ADDR_WIDTH = 5;
    localparam int SCC_CH_NUM     = 5;
    localparam int SCC_MIN_FREQ   = 9;

endpackage : scc_pkg

// File: rtl/scc_tone_step.sv
// -----------------------------------------------------------------------------
// scc_tone_step
// Purely combinational next-state of one tone channel. The top instantiates it
// once and feeds it the counter/address of whichever channel owns the slot.
// Ports:
//   cnt       in  : current down-counter value
//   addr      in  : current wave-table address
//   f         in  : reload value (frequency count)
//   reset     in  : address-reset request for this channel
//   freeze    in  : channel frozen (reload value too small)
//   cnt_next  out : counter after this service
//   addr_next out : address after this service
// -----------------------------------------------------------------------------
module scc_tone_step
    import scc_pkg::*;
#(
    parameter int FREQ_WIDTH = SCC_FREQ_WIDTH,
    parameter int ADDR_WIDTH = SCC_ADDR_WIDTH
) (
    input  logic [FREQ_WIDTH-1:0] cnt,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [FREQ_WIDTH-1:0] f,
    input  logic                  reset,
    input  logic                  freeze,
    output logic [FREQ_WIDTH-1:0] cnt_next,
    output logic [ADDR_WIDTH-1:0] addr_next
);

    // Priority: reset > freeze > terminal count > count down.
    always_comb begin
        cnt_next  = cnt;
        addr_next = addr;
        if (reset) begin
            cnt_next  = f;
            addr_next = '0;
        end else if (freeze) begin
            cnt_next  = cnt;
            addr_next = addr;
        end else if (cnt == '0) begin
            // Reload rather than decrement: the counter never underflows, and
            // the address wraps naturally modulo 2**ADDR_WIDTH.
            cnt_next  = f;
            addr_next = addr + 1'b1;
        end else begin
            cnt_next  = cnt - 1'b1;
        end
    end

endmodule : scc_tone_step

// File: rtl/scc_tone_generator_mux.sv
// -----------------------------------------------------------------------------
// scc_tone_generator_mux
// Time-multiplexed N-channel wave-table tone generator. A slot counter walks
// the channels round-robin on each enable; the owning channel's counter and
// address are stepped by a single shared scc_tone_step instance. One
// (channel, pre-step address) pair is presented one clock after each enable.
// Ports:
//   nreset              in  : asynchronous reset, active low
//   clk                 in  : sole clock
//   enable              in  : slot strobe, one channel serviced per high cycle
//   reg_frequency_count in  : per-channel reload values, ch k at [k*FREQ_WIDTH +: FREQ_WIDTH]
//   address_reset       in  : per-channel single-cycle address-reset pulses
//   wave_valid          out : wave_channel / wave_address valid this cycle
//   wave_channel        out : channel of the presented address
//   wave_address        out : pre-step wave address of wave_channel
//   slot_sync           out : high with wave_valid when wave_channel == 0
// -----------------------------------------------------------------------------
module scc_tone_generator_mux
    import scc_pkg::*;
#(
    parameter  int CH_NUM     = SCC_CH_NUM,
    parameter  int FREQ_WIDTH = SCC_FREQ_WIDTH,
    parameter  int ADDR_WIDTH = SCC_ADDR_WIDTH,
    parameter  int MIN_FREQ   = SCC_MIN_FREQ,
    localparam int CH_W       = $clog2(CH_NUM)
) (
    input  logic                         nreset,
    input  logic                         clk,
    input  logic                         enable,
    input  logic [CH_NUM*FREQ_WIDTH-1:0] reg_frequency_count,
    input  logic [CH_NUM-1:0]            address_reset,
    output logic                         wave_valid,
    output logic [CH_W-1:0]              wave_channel,
    output logic [ADDR_WIDTH-1:0]        wave_address,
    output logic                         slot_sync
);

    localparam logic [FREQ_WIDTH-1:0] MIN_F     = FREQ_WIDTH'(MIN_FREQ);
    localparam logic [CH_W-1:0]       LAST_SLOT = CH_W'(CH_NUM - 1);

    logic [CH_W-1:0]       r_slot;
    logic [CH_NUM-1:0]     r_pend;
    logic [FREQ_WIDTH-1:0] r_cnt  [CH_NUM];
    logic [ADDR_WIDTH-1:0] r_addr [CH_NUM];

    logic                  r_wave_valid;
    logic [CH_W-1:0]       r_wave_channel;
    logic [ADDR_WIDTH-1:0] r_wave_address;
    logic                  r_slot_sync;

    logic [FREQ_WIDTH-1:0] w_freq [CH_NUM];
    logic [FREQ_WIDTH-1:0] w_cur_freq;
    logic [FREQ_WIDTH-1:0] w_cur_cnt;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic                  w_reset;
    logic                  w_freeze;
    logic [FREQ_WIDTH-1:0] w_cnt_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [CH_NUM-1:0]     w_pend_next;
    logic [CH_W-1:0]       w_slot_next;

    // Unpack the flat frequency bus into one entry per channel.
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_freq
        assign w_freq[gi] = reg_frequency_count[gi*FREQ_WIDTH +: FREQ_WIDTH];
    end

    // Operand mux for the shared step datapath.
    assign w_cur_freq = w_freq[r_slot];
    assign w_cur_cnt  = r_cnt[r_slot];
    assign w_cur_addr = r_addr[r_slot];
    // A pulse arriving in the channel's own slot is applied straight away.
    assign w_reset    = r_pend[r_slot] | address_reset[r_slot];
    assign w_freeze   = (w_cur_freq < MIN_F);

    scc_tone_step #(
        .FREQ_WIDTH (FREQ_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_step (
        .cnt       (w_cur_cnt),
        .addr      (w_cur_addr),
        .f         (w_cur_freq),
        .reset     (w_reset),
        .freeze    (w_freeze),
        .cnt_next  (w_cnt_next),
        .addr_next (w_addr_next)
    );

    // Requests are latched every cycle; the serviced bit is cleared after the
    // OR so a same-slot pulse is consumed and never re-latched.
    always_comb begin
        w_pend_next = r_pend | address_reset;
        if (enable) begin
            w_pend_next[r_slot] = 1'b0;
        end
    end

    assign w_slot_next = (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_slot         <= '0;
            r_pend         <= '0;
            r_wave_valid   <= 1'b0;
            r_wave_channel <= '0;
            r_wave_address <= '0;
            r_slot_sync    <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                r_cnt[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_pend       <= w_pend_next;
            r_wave_valid <= enable;
            r_slot_sync  <= enable && (r_slot == '0);
            if (enable) begin
                r_slot         <= w_slot_next;
                r_cnt[r_slot]  <= w_cnt_next;
                r_addr[r_slot] <= w_addr_next;
                r_wave_channel <= r_slot;
                // Present the address as it was before this service's step.
                r_wave_address <= w_cur_addr;
            end
        end
    end

    assign wave_valid   = r_wave_valid;
    assign wave_channel = r_wave_channel;
    assign wave_address = r_wave_address;
    assign slot_sync    = r_slot_sync;

endmodule : scc_tone_generator_mux

// File: tb/tb_scc_tone_generator_mux.sv
// -----------------------------------------------------------------------------
// tb_scc_tone_generator_mux
// Directed bench for the multiplexed tone generator. Each scenario task drives
// its own stimulus and compares outputs inline, one clock after each enable.
// Expected pre-step address of a channel at its n-th service, reload f:
//   no reset since power-up : ((n + f) / (f + 1)) mod 32
//   last reset at service r : ((n - r - 1) / (f + 1)) mod 32
// -----------------------------------------------------------------------------
module tb_scc_tone_generator_mux;

    localparam int CH   = 5;
    localparam int FW   = 12;
    localparam int AW   = 5;
    localparam int MINF = 9;
    localparam int CW   = $clog2(CH);

    logic              clk = 1'b0;
    logic              nreset;
    logic              enable;
    logic [CH*FW-1:0]  reg_frequency_count;
    logic [CH-1:0]     address_reset;
    logic              wave_valid;
    logic [CW-1:0]     wave_channel;
    logic [AW-1:0]     wave_address;
    logic              slot_sync;

    int checks = 0;
    int errors = 0;
    int f_tb [CH];

    scc_tone_generator_mux #(
        .CH_NUM     (CH),
        .FREQ_WIDTH (FW),
        .ADDR_WIDTH (AW),
        .MIN_FREQ   (MINF)
    ) dut (
        .nreset              (nreset),
        .clk                 (clk),
        .enable              (enable),
        .reg_frequency_count (reg_frequency_count),
        .address_reset       (address_reset),
        .wave_valid          (wave_valid),
        .wave_channel        (wave_channel),
        .wave_address        (wave_address),
        .slot_sync           (slot_sync)
    );

    always #5 clk = ~clk;

    function automatic int tone_addr(input int n, input int f, input int r);
        if (r < 0) return ((n + f) / (f + 1)) % (1 << AW);
        return ((n - r - 1) / (f + 1)) % (1 << AW);
    endfunction

    task automatic set_freq();
        for (int i = 0; i < CH; i++) reg_frequency_count[i*FW +: FW] = FW'(f_tb[i]);
    endtask

    // One clock with the given enable/pulses; returns 1 time unit after the edge.
    task automatic step(input logic en, input logic [CH-1:0] pulse);
        enable        = en;
        address_reset = pulse;
        @(posedge clk);
        #1;
        address_reset = '0;
    endtask

    task automatic do_reset();
        nreset        = 1'b0;
        enable        = 1'b0;
        address_reset = '0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset        = 1'b0;
        enable        = 1'b0;
        address_reset = '0;
        for (int i = 0; i < CH; i++) f_tb[i] = 9;
        set_freq();
        #2;
        checks++; if (wave_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", wave_valid); end
        checks++; if (wave_channel !== '0)   begin errors++; $display("FAIL reset_channel: got %0d expected 0", wave_channel); end
        checks++; if (wave_address !== '0)   begin errors++; $display("FAIL reset_address: got %0d expected 0", wave_address); end
        checks++; if (slot_sync !== 1'b0)    begin errors++; $display("FAIL reset_sync: got %b expected 0", slot_sync); end
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, '0);
            checks++; if (wave_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: cycle %0d got %b expected 0", c, wave_valid); end
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    // All channels f=9, continuous enable, long enough to see 31 -> 0 wrap.
    task automatic test_steady_tone();
        int ch, n, exp_a;
        for (int i = 0; i < CH; i++) f_tb[i] = 9;
        set_freq();
        do_reset();
        for (int k = 0; k < 5 * 330; k++) begin
            step(1'b1, '0);
            ch = k % CH; n = k / CH; exp_a = tone_addr(n, 9, -1);
            checks++; if (wave_valid !== 1'b1)          begin errors++; $display("FAIL steady_valid: k=%0d got %b expected 1", k, wave_valid); end
            checks++; if (wave_channel !== CW'(ch))     begin errors++; $display("FAIL steady_channel: k=%0d got %0d expected %0d", k, wave_channel, ch); end
            checks++; if (wave_address !== AW'(exp_a))  begin errors++; $display("FAIL steady_address: k=%0d ch=%0d got %0d expected %0d", k, ch, wave_address, exp_a); end
            checks++; if (slot_sync !== (ch == 0))      begin errors++; $display("FAIL steady_sync: k=%0d got %b expected %b", k, slot_sync, ch == 0); end
        end
        $display("test_steady_tone done: checks=%0d errors=%0d", checks, errors);
    endtask

    // f[2]=8 sits just below the freeze threshold: ch2 must stay at address 0.
    task automatic test_freeze();
        int ch, n, exp_a;
        for (int i = 0; i < CH; i++) f_tb[i] = 9;
        f_tb[2] = 8;
        set_freq();
        do_reset();
        for (int k = 0; k < 500; k++) begin
            step(1'b1, '0);
            ch = k % CH; n = k / CH;
            exp_a = (ch == 2) ? 0 : tone_addr(n, 9, -1);
            checks++; if (wave_channel !== CW'(ch))    begin errors++; $display("FAIL freeze_channel: k=%0d got %0d expected %0d", k, wave_channel, ch); end
            checks++; if (wave_address !== AW'(exp_a)) begin errors++; $display("FAIL freeze_address: k=%0d ch=%0d got %0d expected %0d", k, ch, wave_address, exp_a); end
        end
        $display("test_freeze done: checks=%0d errors=%0d", checks, errors);
    endtask

    // ch3 pulsed while slot 0 is serviced (service 25), then twice before its
    // service 40. Hand values: n=25 ->3, n=26 ->0, n=36 ->1, n=40 ->1, n=41 ->0, n=51 ->1.
    task automatic test_lost_pulse();
        int ch, n, exp_a;
        int rr [CH];
        logic [CH-1:0] pulse;
        logic [CH-1:0] pend;
        for (int i = 0; i < CH; i++) begin f_tb[i] = 9; rr[i] = -1; end
        pend = '0;
        set_freq();
        do_reset();
        for (int k = 0; k < 5 * 60; k++) begin
            pulse = (k == 125 || k == 200 || k == 201) ? 5'b01000 : 5'b00000;
            step(1'b1, pulse);
            ch = k % CH; n = k / CH; exp_a = tone_addr(n, 9, rr[ch]);
            checks++; if (wave_address !== AW'(exp_a)) begin errors++; $display("FAIL lost_pulse_address: k=%0d ch=%0d got %0d expected %0d", k, ch, wave_address, exp_a); end
            for (int c = 0; c < CH; c++) begin
                if (c == ch) begin
                    if (pend[c] || pulse[c]) begin rr[c] = n; pend[c] = 1'b0; end
                end else if (pulse[c]) begin
                    pend[c] = 1'b1;
                end
            end
            if (k == 128) begin checks++; if (wave_address !== 5'd3) begin errors++; $display("FAIL lost_pulse_old_addr: got %0d expected 3", wave_address); end end
            if (k == 133) begin checks++; if (wave_address !== 5'd0) begin errors++; $display("FAIL lost_pulse_cleared: got %0d expected 0", wave_address); end end
            if (k == 258) begin checks++; if (wave_address !== 5'd1) begin errors++; $display("FAIL lost_pulse_single: got %0d expected 1", wave_address); end end
        end
        $display("test_lost_pulse done: checks=%0d errors=%0d", checks, errors);
    endtask

    // f[1]=11: ch1 hits counter==0 at service 12; pulse arrives in that very slot.
    // Hand values: n=12 ->1 (old), n=13 ->0, n=24 ->0, n=25 ->1, n=37 ->2.
    task automatic test_simultaneous();
        int ch, n, exp_a;
        int rr [CH];
        logic [CH-1:0] pulse;
        logic [CH-1:0] pend;
        for (int i = 0; i < CH; i++) begin f_tb[i] = 9; rr[i] = -1; end
        f_tb[1] = 11;
        pend = '0;
        set_freq();
        do_reset();
        for (int k = 0; k < 200; k++) begin
            pulse = (k == 61) ? 5'b00010 : 5'b00000;
            step(1'b1, pulse);
            ch = k % CH; n = k / CH; exp_a = tone_addr(n, f_tb[ch], rr[ch]);
            checks++; if (wave_address !== AW'(exp_a)) begin errors++; $display("FAIL simul_address: k=%0d ch=%0d got %0d expected %0d", k, ch, wave_address, exp_a); end
            for (int c = 0; c < CH; c++) begin
                if (c == ch) begin
                    if (pend[c] || pulse[c]) begin rr[c] = n; pend[c] = 1'b0; end
                end else if (pulse[c]) begin
                    pend[c] = 1'b1;
                end
            end
            if (k == 66)  begin checks++; if (wave_address !== 5'd0) begin errors++; $display("FAIL simul_reset_wins: got %0d expected 0", wave_address); end end
            if (k == 126) begin checks++; if (wave_address !== 5'd1) begin errors++; $display("FAIL simul_reload_f1: got %0d expected 1", wave_address); end end
        end
        $display("test_simultaneous done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_gated_and_midreset();
        int ch, n, exp_a;
        for (int i = 0; i < CH; i++) f_tb[i] = 9;
        set_freq();
        do_reset();
        for (int k = 0; k < 150; k++) begin
            step(1'b1, '0);
            ch = k % CH; n = k / CH; exp_a = tone_addr(n, 9, -1);
            checks++; if (wave_valid !== 1'b1)         begin errors++; $display("FAIL gated_valid: k=%0d got %b expected 1", k, wave_valid); end
            checks++; if (wave_channel !== CW'(ch))    begin errors++; $display("FAIL gated_channel: k=%0d got %0d expected %0d", k, wave_channel, ch); end
            checks++; if (wave_address !== AW'(exp_a)) begin errors++; $display("FAIL gated_address: k=%0d got %0d expected %0d", k, wave_address, exp_a); end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, '0);
                checks++; if (wave_valid !== 1'b0) begin errors++; $display("FAIL gated_idle: k=%0d got %b expected 0", k, wave_valid); end
            end
        end
        // Service 30 of ch0: address 3, then reset lands mid-cycle.
        step(1'b1, '0);
        checks++; if (wave_address !== 5'd3) begin errors++; $display("FAIL prereset_address: got %0d expected 3", wave_address); end
        #3;
        nreset = 1'b0;
        #1;
        checks++; if (wave_valid !== 1'b0)   begin errors++; $display("FAIL midreset_valid: got %b expected 0", wave_valid); end
        checks++; if (wave_channel !== '0)   begin errors++; $display("FAIL midreset_channel: got %0d expected 0", wave_channel); end
        checks++; if (wave_address !== '0)   begin errors++; $display("FAIL midreset_address: got %0d expected 0", wave_address); end
        checks++; if (slot_sync !== 1'b0)    begin errors++; $display("FAIL midreset_sync: got %b expected 0", slot_sync); end
        enable = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        step(1'b0, '0);
        checks++; if (wave_valid !== 1'b0) begin errors++; $display("FAIL restart_idle: got %b expected 0", wave_valid); end
        step(1'b1, '0);
        checks++; if (wave_valid !== 1'b1)   begin errors++; $display("FAIL restart_valid: got %b expected 1", wave_valid); end
        checks++; if (wave_channel !== '0)   begin errors++; $display("FAIL restart_channel: got %0d expected 0", wave_channel); end
        checks++; if (wave_address !== '0)   begin errors++; $display("FAIL restart_address: got %0d expected 0", wave_address); end
        checks++; if (slot_sync !== 1'b1)    begin errors++; $display("FAIL restart_sync: got %b expected 1", slot_sync); end
        step(1'b1, '0);
        checks++; if (wave_channel !== 3'd1) begin errors++; $display("FAIL restart_next_channel: got %0d expected 1", wave_channel); end
        checks++; if (wave_address !== '0)   begin errors++; $display("FAIL restart_next_address: got %0d expected 0", wave_address); end
        $display("test_gated_and_midreset done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        reg_frequency_count = '0;
        address_reset       = '0;
        enable              = 1'b0;
        nreset              = 1'b0;
        test_reset();
        test_steady_tone();
        test_freeze();
        test_lost_pulse();
        test_simultaneous();
        test_gated_and_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_scc_tone_generator_mux
